// File: rtl/fpu_adder_arbiter_if.sv
// Stb/ack bundle joining the two operand requesters, the shared adder and the arbiter.
// The slave modport is the arbiter's view; master is everything around it.
interface fpu_adder_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] req_a_0, req_b_0, rsp_z_0;
  logic             req_stb_0, req_ack_0, rsp_stb_0, rsp_ack_0;
  logic [WIDTH-1:0] req_a_1, req_b_1, rsp_z_1;
  logic             req_stb_1, req_ack_1, rsp_stb_1, rsp_ack_1;
  logic [WIDTH-1:0] adder_a, adder_b, adder_z;
  logic             adder_a_stb, adder_a_ack;
  logic             adder_b_stb, adder_b_ack;
  logic             adder_z_stb, adder_z_ack;
  logic             grant, busy;
  logic [15:0]      op_count;

  modport slave (
    input  req_a_0, req_b_0, req_stb_0, rsp_ack_0,
           req_a_1, req_b_1, req_stb_1, rsp_ack_1,
           adder_a_ack, adder_b_ack, adder_z, adder_z_stb,
    output req_ack_0, rsp_z_0, rsp_stb_0,
           req_ack_1, rsp_z_1, rsp_stb_1,
           adder_a, adder_a_stb, adder_b, adder_b_stb, adder_z_ack,
           grant, busy, op_count
  );

  modport master (
    output req_a_0, req_b_0, req_stb_0, rsp_ack_0,
           req_a_1, req_b_1, req_stb_1, rsp_ack_1,
           adder_a_ack, adder_b_ack, adder_z, adder_z_stb,
    input  req_ack_0, rsp_z_0, rsp_stb_0,
           req_ack_1, rsp_z_1, rsp_stb_1,
           adder_a, adder_a_stb, adder_b, adder_b_stb, adder_z_ack,
           grant, busy, op_count
  );
endinterface

// File: rtl/fpu_adder_arbiter.sv
// Round-robin sharing of one fpu adder between two requesters: accept a pair,
// feed a then b to the adder, collect z and hand it back to the granted requester.
module fpu_adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  fpu_adder_arbiter_if.slave bus
);
  typedef enum logic [2:0] {ARB, ACK, SEND_A, SEND_B, WAIT_Z, RETURN} state_t;

  state_t           r_state;
  logic             r_lastGrant, r_grant, r_busy;
  logic [15:0]      r_opCount;
  logic [WIDTH-1:0] r_a, r_b, r_rspZ;
  logic             r_reqAck0, r_reqAck1, r_rspStb0, r_rspStb1;
  logic             r_adderAStb, r_adderBStb, r_adderZAck;

  logic w_anyReq, w_pick, w_rspStb, w_rspAck;

  // On a tie the requester not served last wins, so grants alternate under load.
  assign w_anyReq = bus.req_stb_0 | bus.req_stb_1;
  assign w_pick   = (bus.req_stb_0 & bus.req_stb_1) ? ~r_lastGrant : bus.req_stb_1;
  assign w_rspStb = r_grant ? r_rspStb1 : r_rspStb0;
  assign w_rspAck = r_grant ? bus.rsp_ack_1 : bus.rsp_ack_0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB;
      r_lastGrant <= 1'b1;
      r_grant     <= 1'b0;
      r_busy      <= 1'b0;
      r_opCount   <= 16'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_rspZ      <= '0;
      r_reqAck0   <= 1'b0;
      r_reqAck1   <= 1'b0;
      r_rspStb0   <= 1'b0;
      r_rspStb1   <= 1'b0;
      r_adderAStb <= 1'b0;
      r_adderBStb <= 1'b0;
      r_adderZAck <= 1'b0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_anyReq) begin
            r_grant   <= w_pick;
            r_a       <= w_pick ? bus.req_a_1 : bus.req_a_0;
            r_b       <= w_pick ? bus.req_b_1 : bus.req_b_0;
            r_reqAck0 <= ~w_pick;
            r_reqAck1 <= w_pick;
            r_busy    <= 1'b1;
            r_state   <= ACK;
          end
        end
        ACK: begin
          r_reqAck0   <= 1'b0;
          r_reqAck1   <= 1'b0;
          r_adderAStb <= 1'b1;
          r_state     <= SEND_A;
        end
        SEND_A: begin
          if (r_adderAStb && bus.adder_a_ack) begin
            r_adderAStb <= 1'b0;
            r_adderBStb <= 1'b1;
            r_state     <= SEND_B;
          end
        end
        SEND_B: begin
          if (r_adderBStb && bus.adder_b_ack) begin
            r_adderBStb <= 1'b0;
            r_adderZAck <= 1'b1;
            r_state     <= WAIT_Z;
          end
        end
        // Both response buses carry z; only the granted side sees its stb.
        WAIT_Z: begin
          if (bus.adder_z_stb && r_adderZAck) begin
            r_rspZ      <= bus.adder_z;
            r_adderZAck <= 1'b0;
            if (r_grant) r_rspStb1 <= 1'b1;
            else         r_rspStb0 <= 1'b1;
            r_state     <= RETURN;
          end
        end
        RETURN: begin
          if (w_rspStb && w_rspAck) begin
            r_rspStb0   <= 1'b0;
            r_rspStb1   <= 1'b0;
            r_opCount   <= r_opCount + 16'd1;
            r_lastGrant <= r_grant;
            r_busy      <= 1'b0;
            r_state     <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign bus.req_ack_0   = r_reqAck0;
  assign bus.req_ack_1   = r_reqAck1;
  assign bus.rsp_z_0     = r_rspZ;
  assign bus.rsp_z_1     = r_rspZ;
  assign bus.rsp_stb_0   = r_rspStb0;
  assign bus.rsp_stb_1   = r_rspStb1;
  assign bus.adder_a     = r_a;
  assign bus.adder_b     = r_b;
  assign bus.adder_a_stb = r_adderAStb;
  assign bus.adder_b_stb = r_adderBStb;
  assign bus.adder_z_ack = r_adderZAck;
  assign bus.grant       = r_grant;
  assign bus.busy        = r_busy;
  assign bus.op_count    = r_opCount;
endmodule

// File: tb/tb_fpu_adder_arbiter.sv
// Scoreboard bench for fpu_adder_arbiter: requester drivers push expected sums at issue,
// response monitors pop and compare on every rsp handshake; a small adder model answers from a table.
module tb_fpu_adder_arbiter;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_adder_arbiter_if #(.WIDTH(WIDTH)) bus ();

  fpu_adder_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Hand-computed IEEE-754 single sums; no entry appears with its operands swapped.
  logic [31:0] vecA [10] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F000000, 32'h40400000,
                             32'h40800000, 32'h3FC00000, 32'h41000000, 32'h40A00000, 32'h00000000};
  logic [31:0] vecB [10] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3F800000,
                             32'h40800000, 32'h3F000000, 32'h41000000, 32'h40400000, 32'h3F800000};
  logic [31:0] vecZ [10] = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h3F800000, 32'h40800000,
                             32'h41000000, 32'h40000000, 32'h41800000, 32'h41000000, 32'h3F800000};

  pair_t       reqQ0[$], reqQ1[$];
  logic [31:0] expQ0[$], expQ1[$];
  logic [31:0] adderLog[$];
  int          grantLog[$];
  int          checks = 0, passes = 0;
  int          rspCount0 = 0, rspCount1 = 0;
  int          aDelay = 0, bDelay = 0, zDelay = 0, rspDelay0 = 0, rspDelay1 = 0;
  logic [15:0] modelCount = 16'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int req, input int idx);
    pair_t p;
    p.a = vecA[idx];
    p.b = vecB[idx];
    p.z = vecZ[idx];
    if (req == 0) reqQ0.push_back(p);
    else          reqQ1.push_back(p);
  endtask

  function automatic logic [31:0] lookupSum(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] z = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) if (vecA[i] == a && vecB[i] == b) z = vecZ[i];
    return z;
  endfunction

  function automatic logic [31:0] handshakes();
    return 32'({bus.req_ack_0, bus.req_ack_1, bus.adder_a_stb, bus.adder_b_stb,
                bus.adder_z_ack, bus.rsp_stb_0, bus.rsp_stb_1});
  endfunction

  // Waits for both response counts to reach their targets, then one more cycle so op_count settles.
  task automatic waitDone(input string name, input int n0, input int n1, input int budget);
    int i = 0;
    while ((rspCount0 < n0 || rspCount1 < n1) && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    checkOutput({name, " completed"}, 32'(rspCount0 < n0 || rspCount1 < n1), 32'd0);
    @(negedge clk); #1;
  endtask

  // Adder model: acks after the configured stalls, drops the result if z_ack is withdrawn by a reset.
  initial begin : adderModel
    int phase = 0;
    int cnt = 0;
    logic [31:0] capA = 32'd0;
    bus.adder_a_ack = 1'b0;
    bus.adder_b_ack = 1'b0;
    bus.adder_z     = 32'd0;
    bus.adder_z_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (phase == 1)      begin bus.adder_a_ack = 1'b0; phase = 2; cnt = 0; end
      else if (phase == 3) begin bus.adder_b_ack = 1'b0; phase = 4; cnt = 0; end
      else if (phase == 5) begin bus.adder_z_stb = 1'b0; phase = 0; cnt = 0; end
      if (phase == 0 && bus.adder_a_stb) begin
        if (cnt < aDelay) cnt++;
        else begin capA = bus.adder_a; adderLog.push_back(capA); bus.adder_a_ack = 1'b1; phase = 1; end
      end else if (phase == 2 && bus.adder_b_stb) begin
        if (cnt < bDelay) cnt++;
        else begin
          adderLog.push_back(bus.adder_b);
          bus.adder_z     = lookupSum(capA, bus.adder_b);
          bus.adder_b_ack = 1'b1;
          phase = 3;
        end
      end else if (phase == 4) begin
        if (!bus.adder_z_ack) begin phase = 0; cnt = 0; end
        else if (cnt < zDelay) cnt++;
        else begin bus.adder_z_stb = 1'b1; phase = 5; end
      end
    end
  end

  initial begin : requester0
    pair_t p;
    logic taken = 1'b0;
    bus.req_a_0 = 32'd0; bus.req_b_0 = 32'd0; bus.req_stb_0 = 1'b0;
    forever begin
      @(negedge clk);
      if (taken) begin bus.req_stb_0 = 1'b0; taken = 1'b0; end
      if (!bus.req_stb_0 && reqQ0.size() > 0) begin
        p = reqQ0.pop_front();
        bus.req_a_0 = p.a; bus.req_b_0 = p.b; bus.req_stb_0 = 1'b1;
        expQ0.push_back(p.z);
      end else if (bus.req_stb_0 && bus.req_ack_0) begin
        taken = 1'b1;
        grantLog.push_back(0);
      end
    end
  end

  initial begin : requester1
    pair_t p;
    logic taken = 1'b0;
    bus.req_a_1 = 32'd0; bus.req_b_1 = 32'd0; bus.req_stb_1 = 1'b0;
    forever begin
      @(negedge clk);
      if (taken) begin bus.req_stb_1 = 1'b0; taken = 1'b0; end
      if (!bus.req_stb_1 && reqQ1.size() > 0) begin
        p = reqQ1.pop_front();
        bus.req_a_1 = p.a; bus.req_b_1 = p.b; bus.req_stb_1 = 1'b1;
        expQ1.push_back(p.z);
      end else if (bus.req_stb_1 && bus.req_ack_1) begin
        taken = 1'b1;
        grantLog.push_back(1);
      end
    end
  end

  initial begin : monitor0
    int waitCnt = 0;
    logic acking = 1'b0;
    bus.rsp_ack_0 = 1'b0;
    forever begin
      @(negedge clk);
      if (acking) begin bus.rsp_ack_0 = 1'b0; acking = 1'b0; end
      else if (bus.rsp_stb_0) begin
        if (waitCnt < rspDelay0) waitCnt++;
        else begin
          waitCnt = 0; bus.rsp_ack_0 = 1'b1; acking = 1'b1;
          if (expQ0.size() == 0) begin
            checks++;
            $display("[TB] FAIL rsp0 unexpected: got 0x%08h, want no response", bus.rsp_z_0);
          end else checkOutput("rsp_z_0", bus.rsp_z_0, expQ0.pop_front());
          checkOutput("rsp0 grant", 32'(bus.grant), 32'd0);
          rspCount0++;
          modelCount++;
        end
      end
    end
  end

  initial begin : monitor1
    int waitCnt = 0;
    logic acking = 1'b0;
    bus.rsp_ack_1 = 1'b0;
    forever begin
      @(negedge clk);
      if (acking) begin bus.rsp_ack_1 = 1'b0; acking = 1'b0; end
      else if (bus.rsp_stb_1) begin
        if (waitCnt < rspDelay1) waitCnt++;
        else begin
          waitCnt = 0; bus.rsp_ack_1 = 1'b1; acking = 1'b1;
          if (expQ1.size() == 0) begin
            checks++;
            $display("[TB] FAIL rsp1 unexpected: got 0x%08h, want no response", bus.rsp_z_1);
          end else checkOutput("rsp_z_1", bus.rsp_z_1, expQ1.pop_front());
          checkOutput("rsp1 grant", 32'(bus.grant), 32'd1);
          rspCount1++;
          modelCount++;
        end
      end
    end
  end

  initial begin : stimulus
    int t0, t1, c, base0, base1, stbViol, busyViol, ackViol, hiCnt;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset op_count", 32'(bus.op_count), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset grant", 32'(bus.grant), 32'd0);
    checkOutput("reset handshakes", handshakes(), 32'd0);
    checkOutput("reset adder_a", bus.adder_a, 32'd0);
    checkOutput("reset rsp_z_0", bus.rsp_z_0, 32'd0);
    rst = 1'b0;

    $display("[TB] single request from requester 0");
    applyStimulus(0, 0);
    t0 = -1; t1 = -1; c = 0;
    while (t1 < 0 && c < 50) begin
      @(negedge clk); #1;
      if (t0 < 0 && bus.req_ack_0) t0 = c;
      if (t1 < 0 && bus.rsp_stb_0) t1 = c;
      c++;
    end
    checkOutput("t1 accept-to-rsp latency", 32'(t1 - t0), 32'd4);
    waitDone("t1", 1, 0, 50);
    checkOutput("t1 op_count", 32'(bus.op_count), 32'd1);
    checkOutput("t1 rsp1 count", 32'(rspCount1), 32'd0);
    checkOutput("t1 adder log size", 32'(adderLog.size()), 32'd2);
    if (adderLog.size() >= 2) begin
      checkOutput("t1 adder_a first", adderLog[0], 32'h3F800000);
      checkOutput("t1 adder_b second", adderLog[1], 32'h40000000);
    end

    $display("[TB] both requesters streaming from reset");
    rst = 1'b1;
    modelCount = 16'd0;
    grantLog.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, i);
      applyStimulus(1, 4 + i);
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    waitDone("t2", 5, 4, 300);
    checkOutput("t2 op_count", 32'(bus.op_count), 32'd8);
    checkOutput("t2 grant log size", 32'(grantLog.size()), 32'd8);
    for (int i = 0; i < grantLog.size() && i < 8; i++)
      checkOutput($sformatf("t2 grant %0d", i), 32'(grantLog[i]), 32'(i % 2));

    $display("[TB] adder stalls b for 10 and z for 20");
    bDelay = 10; zDelay = 20;
    base0 = rspCount0;
    applyStimulus(0, 8);
    c = 0;
    while (!bus.adder_b_stb && c < 50) begin @(negedge clk); #1; c++; end
    checkOutput("t3 adder_b_stb seen", 32'(bus.adder_b_stb), 32'd1);
    stbViol = 0; busyViol = 0; ackViol = 0; c = 0;
    while (rspCount0 < base0 + 1 && c < 100) begin
      if (c < 10 && (!bus.adder_b_stb || bus.adder_b !== 32'h40400000)) stbViol++;
      if (!bus.busy) busyViol++;
      if (bus.req_ack_0 || bus.req_ack_1) ackViol++;
      @(negedge clk); #1;
      c++;
    end
    checkOutput("t3 adder_b held stable", 32'(stbViol), 32'd0);
    checkOutput("t3 busy held", 32'(busyViol), 32'd0);
    checkOutput("t3 spurious req_ack", 32'(ackViol), 32'd0);
    waitDone("t3", base0 + 1, 0, 50);
    bDelay = 0; zDelay = 0;
    checkOutput("t3 op_count", 32'(bus.op_count), 32'(modelCount));

    $display("[TB] requester 1 delays its rsp_ack while requester 0 waits");
    rspDelay1 = 7;
    base0 = rspCount0; base1 = rspCount1;
    applyStimulus(1, 9);
    c = 0;
    while (!bus.req_ack_1 && c < 20) begin @(negedge clk); #1; c++; end
    checkOutput("t4 req_ack_1 seen", 32'(bus.req_ack_1), 32'd1);
    applyStimulus(0, 4);
    ackViol = 0; hiCnt = 0; c = 0;
    while (rspCount1 < base1 + 1 && c < 100) begin
      @(negedge clk); #1;
      if (bus.req_ack_0) ackViol++;
      if (bus.rsp_stb_1) hiCnt++;
      c++;
    end
    checkOutput("t4 early req_ack_0", 32'(ackViol), 32'd0);
    checkOutput("t4 rsp_stb_1 held cycles", 32'(hiCnt), 32'd8);
    @(negedge clk); #1;
    checkOutput("t4 req_ack_0 in ARB cycle", 32'(bus.req_ack_0), 32'd0);
    @(negedge clk); #1;
    checkOutput("t4 req_ack_0 after decision", 32'(bus.req_ack_0), 32'd1);
    checkOutput("t4 grant after decision", 32'(bus.grant), 32'd0);
    rspDelay1 = 0;
    waitDone("t4", base0 + 1, base1 + 1, 50);
    checkOutput("t4 op_count", 32'(bus.op_count), 32'(modelCount));

    $display("[TB] reset while waiting for z");
    zDelay = 1000;
    base0 = rspCount0; base1 = rspCount1;
    applyStimulus(0, 5);
    c = 0;
    while (!bus.adder_z_ack && c < 30) begin @(negedge clk); #1; c++; end
    checkOutput("t5 adder_z_ack seen", 32'(bus.adder_z_ack), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    checkOutput("t5 handshakes after reset", handshakes(), 32'd0);
    checkOutput("t5 op_count after reset", 32'(bus.op_count), 32'd0);
    checkOutput("t5 busy after reset", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    expQ0.delete();
    modelCount = 16'd0;
    zDelay = 0;
    applyStimulus(1, 6);
    waitDone("t5", base0, base1 + 1, 50);
    checkOutput("t5 op_count", 32'(bus.op_count), 32'd1);
    checkOutput("t5 no rsp to requester 0", 32'(rspCount0), 32'(base0));

    $display("[TB] op_count wrap");
    base1 = rspCount1;
    @(negedge clk);
    force dut.r_opCount = 16'hFFFF;
    @(negedge clk);
    release dut.r_opCount;
    modelCount = 16'hFFFF;
    #1;
    checkOutput("t6 preload", 32'(bus.op_count), 32'h0000FFFF);
    applyStimulus(1, 7);
    waitDone("t6", rspCount0, base1 + 1, 50);
    checkOutput("t6 wrap", 32'(bus.op_count), 32'd0);
    checkOutput("t6 model count", 32'(bus.op_count), 32'(modelCount));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no completion, want summary before timeout");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
